// File: rtl/regfile_sb.sv
// Integer register file with NR_RD combinational read ports, one write-back port,
// x0 hardwired to zero, optional write-back forwarding and a pending-write scoreboard.

module regfile_sb_rdport #(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 5,
  parameter int DEPTH   = 32,
  parameter int BYPASS  = 1
) (
  input  logic [A_WIDTH-1:0]            addr,
  input  logic [DEPTH-1:0][D_WIDTH-1:0] mem,
  input  logic [DEPTH-1:0]              busy,
  input  logic                          wb_en,
  input  logic [A_WIDTH-1:0]            wb_addr,
  input  logic [D_WIDTH-1:0]            wb_data,
  output logic [D_WIDTH-1:0]            data,
  output logic                          pend
);
  logic zero, hit;

  assign zero = (addr == '0);
  // the retiring write hides the stale value and the busy flag in the same cycle
  assign hit  = (BYPASS != 0) && wb_en && (wb_addr == addr);
  assign data = zero ? '0 : (hit ? wb_data : mem[addr]);
  assign pend = !zero && busy[addr] && !hit;
endmodule

module regfile_sb #(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 5,
  parameter int NR_RD   = 2,
  parameter int BYPASS  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NR_RD*A_WIDTH-1:0]   rd_addr,
  output logic [NR_RD*D_WIDTH-1:0]   rd_data,
  output logic [NR_RD-1:0]           rd_busy,
  input  logic                       issue_en,
  input  logic [A_WIDTH-1:0]         issue_addr,
  input  logic                       wb_en,
  input  logic [A_WIDTH-1:0]         wb_addr,
  input  logic [D_WIDTH-1:0]         wb_data,
  input  logic [A_WIDTH-1:0]         dbg_addr,
  output logic [D_WIDTH-1:0]         dbg_data,
  output logic [(2**A_WIDTH)-1:0]    busy_vec
);
  localparam int DEPTH = 2**A_WIDTH;

  logic [DEPTH-1:0][D_WIDTH-1:0] mem;
  logic [DEPTH-1:0]              busy;

  // x0 is never written or marked, so mem[0] and busy[0] stay at their reset zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem  <= '0;
      busy <= '0;
    end else begin
      if (wb_en && wb_addr != '0) begin
        mem[wb_addr]  <= wb_data;
        busy[wb_addr] <= 1'b0;
      end
      // issued after the clear so a same-register issue (newer producer) wins
      if (issue_en && issue_addr != '0)
        busy[issue_addr] <= 1'b1;
    end
  end

  for (genvar i = 0; i < NR_RD; i++) begin : g_rd
    regfile_sb_rdport #(
      .D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH), .DEPTH(DEPTH), .BYPASS(BYPASS)
    ) u_rd (
      .addr    (rd_addr[i*A_WIDTH +: A_WIDTH]),
      .mem     (mem),
      .busy    (busy),
      .wb_en   (wb_en),
      .wb_addr (wb_addr),
      .wb_data (wb_data),
      .data    (rd_data[i*D_WIDTH +: D_WIDTH]),
      .pend    (rd_busy[i])
    );
  end

  assign dbg_data = mem[dbg_addr];
  assign busy_vec = busy;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench: a 3-port forwarding instance and a 2-port non-forwarding instance
// share stimulus; expectations are queued when driven and checked at the falling edge.

module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [14:0] rd_addr;
  logic [9:0]  rd_addr_b;
  logic [95:0] rd_data_a;
  logic [63:0] rd_data_b;
  logic [2:0]  rd_busy_a;
  logic [1:0]  rd_busy_b;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data_a, dbg_data_b;
  logic [31:0] busy_vec_a, busy_vec_b;

  int vectors = 0;
  int miscompares = 0;

  typedef enum int {RD_A, BUSY_A, DBG_A, BV_BIT_A, BV_A, RD_B, BUSY_B, DBG_B, RD_ALL_A} kind_t;
  typedef struct {
    string       tag;
    kind_t       kind;
    int          idx;
    logic [95:0] exp;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  assign rd_addr_b = rd_addr[9:0];

  regfile_sb #(.D_WIDTH(32), .A_WIDTH(5), .NR_RD(3), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .issue_en(issue_en), .issue_addr(issue_addr), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data_a), .busy_vec(busy_vec_a)
  );

  regfile_sb #(.D_WIDTH(32), .A_WIDTH(5), .NR_RD(2), .BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .issue_en(issue_en), .issue_addr(issue_addr), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data_b), .busy_vec(busy_vec_b)
  );

  function automatic logic [95:0] observe(kind_t k, int i);
    case (k)
      RD_A:     return {64'h0, rd_data_a[i*32 +: 32]};
      BUSY_A:   return {95'h0, rd_busy_a[i]};
      DBG_A:    return {64'h0, dbg_data_a};
      BV_BIT_A: return {95'h0, busy_vec_a[i]};
      BV_A:     return {64'h0, busy_vec_a};
      RD_B:     return {64'h0, rd_data_b[i*32 +: 32]};
      BUSY_B:   return {95'h0, rd_busy_b[i]};
      DBG_B:    return {64'h0, dbg_data_b};
      default:  return rd_data_a;
    endcase
  endfunction

  task automatic expect_val(input string tag, input kind_t k, input int i, input logic [95:0] e);
    exp_t x;
    x.tag = tag; x.kind = k; x.idx = i; x.exp = e;
    sb.push_back(x);
  endtask

  // sample combinational outputs mid-cycle, then let the rising edge commit
  task automatic tick();
    exp_t x;
    logic [95:0] o;
    @(negedge clk);
    while (sb.size() > 0) begin
      x = sb.pop_front();
      o = observe(x.kind, x.idx);
      vectors++;
      assert (o === x.exp) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", x.tag, o, x.exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    wb_en = en; wb_addr = a; wb_data = d;
  endtask

  task automatic issue(input logic en, input logic [4:0] a);
    issue_en = en; issue_addr = a;
  endtask

  initial begin
    rst_n = 1'b0; rd_addr = '0; dbg_addr = '0;
    wb(0, 0, 0); issue(0, 0);
    tick();
    rst_n = 1'b1;

    expect_val("reset_rd0", RD_A, 0, 96'h0);
    expect_val("reset_busy_vec", BV_A, 0, 96'h0);
    expect_val("reset_dbg", DBG_A, 0, 96'h0);
    tick();

    // populate x5, then reset with a competing write and issue in the same cycle
    wb(1, 5, 32'hDEADBEEF);
    tick();
    wb(0, 0, 0); rd_addr[4:0] = 5; dbg_addr = 5;
    expect_val("pre_reset_x5", RD_A, 0, 96'hDEADBEEF);
    expect_val("pre_reset_dbg_x5", DBG_A, 0, 96'hDEADBEEF);
    tick();
    rst_n = 1'b0; wb(1, 5, 32'h12345678); issue(1, 6);
    tick();
    rst_n = 1'b1; wb(0, 0, 0); issue(0, 0);
    expect_val("post_reset_x5", RD_A, 0, 96'h0);
    expect_val("post_reset_dbg_x5", DBG_A, 0, 96'h0);
    expect_val("post_reset_dbg_x5_nb", DBG_B, 0, 96'h0);
    expect_val("post_reset_busy_vec", BV_A, 0, 96'h0);
    tick();

    // x0 hardwire
    rd_addr = '0; dbg_addr = 0;
    wb(1, 0, 32'hFFFFFFFF); issue(1, 0);
    expect_val("x0_same_rd0", RD_A, 0, 96'h0);
    expect_val("x0_same_rd1", RD_A, 1, 96'h0);
    expect_val("x0_same_busy", BUSY_A, 0, 96'h0);
    expect_val("x0_same_rd0_nb", RD_B, 0, 96'h0);
    tick();
    wb(0, 0, 0); issue(0, 0);
    expect_val("x0_next_rd0", RD_A, 0, 96'h0);
    expect_val("x0_next_dbg", DBG_A, 0, 96'h0);
    expect_val("x0_next_busy_vec", BV_A, 0, 96'h0);
    tick();

    // forwarding vs stored value
    wb(1, 7, 32'h11);
    tick();
    wb(1, 7, 32'h22); rd_addr[4:0] = 7; rd_addr[9:5] = 7; dbg_addr = 7;
    expect_val("byp_rd0", RD_A, 0, 96'h22);
    expect_val("byp_rd1", RD_A, 1, 96'h22);
    expect_val("byp_dbg_old", DBG_A, 0, 96'h11);
    expect_val("nobyp_rd0_old", RD_B, 0, 96'h11);
    expect_val("nobyp_rd1_old", RD_B, 1, 96'h11);
    tick();
    wb(0, 0, 0);
    expect_val("byp_rd0_next", RD_A, 0, 96'h22);
    expect_val("byp_dbg_new", DBG_A, 0, 96'h22);
    expect_val("nobyp_rd0_new", RD_B, 0, 96'h22);
    tick();

    // scoreboard: issue x3 at cycle 0, write back at cycle 3
    rd_addr = '0; rd_addr[4:0] = 3;
    issue(1, 3);
    expect_val("sb_c0_busy", BUSY_A, 0, 96'h0);
    tick();
    issue(0, 0);
    expect_val("sb_c1_busy", BUSY_A, 0, 96'h1);
    expect_val("sb_c1_vec3", BV_BIT_A, 3, 96'h1);
    tick();
    expect_val("sb_c2_busy", BUSY_A, 0, 96'h1);
    tick();
    wb(1, 3, 32'h5A);
    expect_val("sb_c3_busy", BUSY_A, 0, 96'h0);
    expect_val("sb_c3_rd", RD_A, 0, 96'h5A);
    expect_val("sb_c3_busy_nb", BUSY_B, 0, 96'h1);
    expect_val("sb_c3_vec3", BV_BIT_A, 3, 96'h1);
    tick();
    wb(0, 0, 0);
    expect_val("sb_c4_vec3", BV_BIT_A, 3, 96'h0);
    expect_val("sb_c4_busy", BUSY_A, 0, 96'h0);
    expect_val("sb_c4_rd", RD_A, 0, 96'h5A);
    tick();

    // simultaneous issue and write-back on the same register: set wins
    issue(1, 9);
    tick();
    wb(1, 9, 32'h77); issue(1, 9);
    tick();
    wb(0, 0, 0); issue(0, 0); rd_addr[4:0] = 9;
    expect_val("sim_rd", RD_A, 0, 96'h77);
    expect_val("sim_vec9", BV_BIT_A, 9, 96'h1);
    expect_val("sim_busy", BUSY_A, 0, 96'h1);
    tick();

    // three concurrent ports; writes to non-busy registers leave busy clear
    wb(1, 1, 32'h1);
    tick();
    wb(1, 2, 32'h2);
    tick();
    wb(1, 31, 32'hCAFEF00D);
    tick();
    wb(0, 0, 0);
    rd_addr = {5'd31, 5'd2, 5'd1};
    expect_val("multi_packed", RD_ALL_A, 0, {32'hCAFEF00D, 32'h2, 32'h1});
    expect_val("final_busy_vec", BV_A, 0, 96'h200);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
